spart_rx: RTL

Receive half of the SPART, downstream of the processor driver's bus transactions. It oversamples the serial RxD line at 16x the baud rate and frames 8N1 characters, LSB first. It holds the received byte for the SPART bus interface, which returns it to the driver on a read of ioaddr 00. It raises rda, the driver's receive-data-available input, and clears it when the bus interface signals that the byte has been read.

---
 rtl/spart_rx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 framer with a receive-data-available
// flag for the bus interface, plus framing-error and overrun status.
module spart_rx #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             rxd,
  input  logic             rd_data,
  output logic [7:0]       rx_data,
  output logic             rda,
  output logic             framing_err,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic [3:0]             sub_q, sub_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [DIV_W-1:0]       cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             rx_data_q;
  logic                   rda_q, fe_q, ovr_q;
  logic                   tick, rxd_s, complete;

  // Sample-rate down-counter; a new divisor is only picked up on reload.
  always_ff @(posedge clk) begin
    if (rst || tick) cnt_q <= divisor;
    else             cnt_q <= cnt_q - 1'b1;
  end

  assign tick = (cnt_q == '0);

  // Metastability chain on the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Framer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      sub_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Framer next-state: everything advances on sample ticks only. Arming
  // needs a high sample, so a line stuck low after a break cannot retrigger.
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    sub_d    = sub_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    complete = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            sub_d   = 4'd0;
          end
        end
        START: begin
          if (sub_q == 4'd7) begin
            // Mid start bit: still low means a real start, else a glitch.
            if (!rxd_s) begin
              state_d = DATA;
              sub_d   = 4'd0;
              bit_d   = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        DATA: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shift_d = {rxd_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
              sub_d   = 4'd0;
            end
          end
        end
        STOP: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            complete = 1'b1;
            state_d  = IDLE;
            armed_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status/data registers; a completion beats a coincident read, and
  // overrun only flags a byte that was overwritten without being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= 8'h00;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (complete) begin
      rx_data_q <= shift_q;
      rda_q     <= 1'b1;
      fe_q      <= ~rxd_s;
      ovr_q     <= rda_q & ~rd_data;
    end else if (rd_data) begin
      rda_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun     = ovr_q;

endmodule
